// File: rtl/photon_pkg.sv
// Shared definitions for the PHOTON-style permutation: geometry, state type,
// controller FSM encoding and the AddConstants tables.
package photon_pkg;

    localparam int STATE_W    = 100;
    localparam int CELL_W     = 4;
    localparam int DIM        = 5;
    localparam int NUM_ROUNDS = 12;
    localparam int RND_W      = 5;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Round constants (one per round) and per-row internal constants for d=5.
    localparam logic [CELL_W-1:0] RC [NUM_ROUNDS] = '{
        4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA
    };
    localparam logic [CELL_W-1:0] IC [DIM] = '{4'h0, 4'h1, 4'h3, 4'h6, 4'h4};

    // Constant XORed into column 0 of a given row during round v.
    function automatic logic [CELL_W-1:0] ac_const(input logic [RND_W-1:0] v,
                                                   input int row);
        logic [CELL_W-1:0] rc;
        rc = (int'(v) < NUM_ROUNDS) ? RC[int'(v)] : '0;
        return rc ^ IC[row % DIM];
    endfunction

endpackage

// File: rtl/photon_round_ctrl.sv
// Iterative round sequencer: accepts a state, drives the external round
// datapath once per clock for NUM_ROUNDS rounds, then offers the result.
module photon_round_ctrl
    import photon_pkg::*;
#(
    parameter int STATE_W    = photon_pkg::STATE_W,
    parameter int NUM_ROUNDS = photon_pkg::NUM_ROUNDS  // legal range 1..31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic [4:0]         rnd_v,
    output logic [STATE_W-1:0] rnd_state_q,
    input  logic [STATE_W-1:0] rnd_state_d,
    output logic               busy
);

    localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS - 1);

    ctrl_state_e        fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [4:0]         round_q, round_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = state_in;
                    round_d = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = rnd_state_d;
                if (round_q == LAST_RND) begin
                    round_d = '0;
                    fsm_d   = DONE;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            DONE: begin
                // state_q is frozen here so state_out is stable until taken.
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Handshakes decode from FSM state only; rst_n gating keeps the source
    // from seeing ready while reset is being applied.
    assign in_ready    = rst_n && (fsm_q == IDLE);
    assign out_valid   = (fsm_q == DONE);
    assign busy        = (fsm_q == RUN);
    assign rnd_v       = (fsm_q == RUN) ? round_q : 5'd0;
    assign state_out   = state_q;
    assign rnd_state_q = state_q;

endmodule

// File: tb/tb_photon_round_ctrl.sv
// Scoreboard bench for photon_round_ctrl using stub round datapaths.
module tb_photon_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [99:0] state_in, state_out, rq, rd;
    logic [4:0]  rnd_v;
    logic        mode;  // 0: +1 stub, 1: xor-round-index stub

    logic        in_valid5, in_ready5, out_valid5, out_ready5, busy5;
    logic [99:0] state_in5, state_out5, rq5, rd5;
    logic [4:0]  rnd_v5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [99:0] expq  [$];
    logic [99:0] expq5 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd  = mode ? (rq ^ {95'b0, rnd_v}) : (rq + 100'd1);
    assign rd5 = rq5 ^ {95'b0, rnd_v5};

    photon_round_ctrl #(.STATE_W(100), .NUM_ROUNDS(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .rnd_v(rnd_v), .rnd_state_q(rq),
        .rnd_state_d(rd), .busy(busy));

    photon_round_ctrl #(.STATE_W(100), .NUM_ROUNDS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .state_in(state_in5), .out_valid(out_valid5), .out_ready(out_ready5),
        .state_out(state_out5), .rnd_v(rnd_v5), .rnd_state_q(rq5),
        .rnd_state_d(rd5), .busy(busy5));

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expected result on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) chk("unexpected_out", state_out, 100'hx);
            else chk("scoreboard_out", state_out, expq.pop_front());
        end
        if (rst_n && out_valid5 && out_ready5) begin
            if (expq5.size() == 0) chk("unexpected_out5", state_out5, 100'hx);
            else chk("scoreboard_out5", state_out5, expq5.pop_front());
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || expq5.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk(name, 100'(expq.size() + expq5.size()), 100'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc [2];
        int nacc;
        int n;
        bit ok;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; mode = 1'b0;
        in_valid5 = 1'b0; out_ready5 = 1'b0; state_in5 = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready", 100'(in_ready), 100'd0);
        chk("rst_out_valid", 100'(out_valid), 100'd0);
        chk("rst_busy", 100'(busy), 100'd0);
        chk("rst_rnd_v", 100'(rnd_v), 100'd0);
        chk("rst_state_out", state_out, 100'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 100'(in_ready), 100'd1);

        // Count: +1 stub from zero, rnd_v walks 0..11, latency 12.
        tick();
        in_valid = 1'b1; state_in = '0;
        expq.push_back(100'h00C);
        tick();
        in_valid = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rnd_v !== 5'(k) || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
                ok = 1'b0;
            if (k < 11) tick();
        end
        chk("run_rnd_v_seq", 100'(ok), 100'd1);
        tick();
        @(negedge clk);
        chk("latency12_out_valid", 100'(out_valid), 100'd1);
        chk("done_state_out", state_out, 100'h00C);
        chk("done_rnd_v_zero", 100'(rnd_v), 100'd0);

        // Backpressure for 20 cycles.
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk);
            if (out_valid !== 1'b1 || state_out !== 100'h00C || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("backpressure_hold", 100'(ok), 100'd1);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("release_out_valid", 100'(out_valid), 100'd0);
        chk("release_in_ready", 100'(in_ready), 100'd1);
        chk("queue_after_release", 100'(expq.size()), 100'd0);

        // Back-to-back with in_valid held.
        tick();
        in_valid = 1'b1; state_in = 100'h100;
        expq.push_back(100'h10C);
        expq.push_back(100'h10C);
        nacc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready && nacc < 2) begin
                acc[nacc] = cyc;
                nacc++;
            end
            tick();
            if (nacc == 2) break;
        end
        in_valid = 1'b0;
        chk("b2b_accept_count", 100'(nacc), 100'd2);
        if (nacc == 2) chk("b2b_interval", 100'(acc[1] - acc[0]), 100'd14);
        drain("b2b_drain");

        // Mid-run reset during round 5 aborts the operation.
        tick();
        in_valid = 1'b1; state_in = 100'h55;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (rnd_v == 5'd4 && busy) break;
            tick();
            n++;
        end
        chk("reach_round4", 100'(n < 30), 100'd1);
        tick();
        chk("round5_rnd_v", 100'(rnd_v), 100'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_state_out", state_out, 100'd0);
        chk("abort_busy", 100'(busy), 100'd0);
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("abort_no_out_valid", 100'(ok), 100'd1);
        in_valid = 1'b1; state_in = 100'h200;
        expq.push_back(100'h20C);
        tick();
        in_valid = 1'b0;
        drain("post_abort_drain");

        // XOR stub: xor of 0..11 is zero; nonzero input passes through.
        mode = 1'b1;
        tick();
        in_valid = 1'b1; state_in = '0;
        expq.push_back(100'h0);
        tick();
        in_valid = 1'b0;
        drain("xor12_zero_drain");
        in_valid = 1'b1; state_in = 100'h300;
        expq.push_back(100'h300);
        tick();
        in_valid = 1'b0;
        drain("xor12_nonzero_drain");

        // NUM_ROUNDS=5 instance: 0^1^2^3^4 = 4, latency 5.
        in_valid5 = 1'b1; state_in5 = '0;
        expq5.push_back(100'h4);
        tick();
        in_valid5 = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid5 !== 1'b0 || rnd_v5 !== 5'(k)) ok = 1'b0;
            tick();
        end
        chk("nr5_run_seq", 100'(ok), 100'd1);
        @(negedge clk);
        chk("nr5_latency_out_valid", 100'(out_valid5), 100'd1);
        chk("nr5_state_out", state_out5, 100'h4);
        tick();
        out_ready5 = 1'b1;
        drain("nr5_drain");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
